// File: rtl/sr_cmd_pkg.sv
// Shared encodings for the SR flip-flop command driver: op codes, FSM states
// and sticky error bit positions.
package sr_cmd_pkg;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_CLR    = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int ERR_MISMATCH = 0;
    localparam int ERR_TOGGLE   = 1;

endpackage

// File: rtl/sr_cmd_fifo.sv
// Small synchronous command FIFO; pointers carry one extra wrap bit so that
// full and empty are told apart without a separate occupancy counter.
module sr_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] wdata,
    output logic [1:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [1:0]  mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/sr_cmd_driver.sv
// Turns queued set/clear/toggle/no-op requests into one-cycle, never-overlapping
// S/R pulses and confirms each write by reading Q back one cycle later.
module sr_cmd_driver
    import sr_cmd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    output logic             s_out,
    output logic             r_out,
    input  logic             q_fb,
    output logic             busy,
    output logic [1:0]       err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] done_cnt,
    output state_t           state
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic [1:0] head;
    logic       exp_q;
    logic       q_known;
    logic [1:0] err_set;

    // Valid/ready: a command transfers on a rising edge where in_valid and
    // in_ready are both high; in_ready depends only on registered FIFO state.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && !empty;
    assign busy     = (state != IDLE) || !empty;

    sr_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_op),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        err_set = 2'b00;
        if (pop && head == OP_TOGGLE && !q_known) err_set[ERR_TOGGLE] = 1'b1;
        if (state == CHECK && q_fb != exp_q)       err_set[ERR_MISMATCH] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_out    <= 1'b0;
            r_out    <= 1'b0;
            exp_q    <= 1'b0;
            q_known  <= 1'b0;
            err      <= 2'b00;
            done_cnt <= '0;
        end else begin
            // A new error in the same cycle as err_clr still lands.
            err   <= (err & ~{2{err_clr}}) | err_set;
            s_out <= 1'b0;
            r_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        case (head)
                            OP_NOP: done_cnt <= done_cnt + CNT_ONE;
                            OP_SET: begin
                                s_out <= 1'b1;
                                exp_q <= 1'b1;
                                state <= DRIVE;
                            end
                            OP_CLR: begin
                                r_out <= 1'b1;
                                exp_q <= 1'b0;
                                state <= DRIVE;
                            end
                            default: begin
                                if (q_known) begin
                                    s_out <= ~q_fb;
                                    r_out <= q_fb;
                                    exp_q <= ~q_fb;
                                    state <= DRIVE;
                                end else begin
                                    done_cnt <= done_cnt + CNT_ONE;
                                end
                            end
                        endcase
                    end
                end
                DRIVE: state <= CHECK;
                CHECK: begin
                    if (q_fb == exp_q) q_known <= 1'b1;
                    done_cnt <= done_cnt + CNT_ONE;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed plus randomized bench for sr_cmd_driver driving a behavioural SR flop.
module tb_sr_cmd_driver;
    import sr_cmd_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [1:0]       in_op = 2'b00;
    logic             err_clr = 1'b0;
    logic             q_fb;
    logic             in_ready;
    logic             s_out;
    logic             r_out;
    logic             busy;
    logic [1:0]       err;
    logic [CNT_W-1:0] done_cnt;
    state_t           state;

    int checks = 0;
    int errors = 0;

    // behavioural SR flip-flop, optionally stuck at 0
    logic flop_q = 1'b0;
    logic stuck = 1'b0;
    assign q_fb = flop_q;

    // command-level reference model
    logic             m_q = 1'b0;
    logic             m_known = 1'b0;
    logic [1:0]       m_err = 2'b00;
    logic [CNT_W-1:0] m_cnt = '0;
    logic [1:0]       exp_q[$];
    logic             s_prev = 1'b0;
    logic             r_prev = 1'b0;

    sr_cmd_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .s_out    (s_out),
        .r_out    (r_out),
        .q_fb     (q_fb),
        .busy     (busy),
        .err      (err),
        .err_clr  (err_clr),
        .done_cnt (done_cnt),
        .state    (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (stuck)      flop_q <= 1'b0;
        else if (s_out) flop_q <= 1'b1;
        else if (r_out) flop_q <= 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // every cycle: no S/R overlap, pulses one cycle wide, pulses in expected order
    always @(negedge clk) begin
        logic [1:0] want;
        check("sr_overlap", 32'(s_out & r_out), 32'd0);
        check("s_width", 32'(s_out & s_prev), 32'd0);
        check("r_width", 32'(r_out & r_prev), 32'd0);
        if ((s_out && !s_prev) || (r_out && !r_prev)) begin
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b11;
            check("pulse_kind", 32'({s_out, r_out}), 32'(want));
        end
        s_prev = s_out;
        r_prev = r_out;
    end

    task automatic resolve(input logic e);
        logic actual;
        actual = stuck ? 1'b0 : e;
        if (actual == e) m_known = 1'b1;
        else             m_err[0] = 1'b1;
        m_q   = actual;
        m_cnt = m_cnt + 1'b1;
    endtask

    task automatic model(input logic [1:0] op);
        logic e;
        case (op)
            OP_NOP: m_cnt = m_cnt + 1'b1;
            OP_SET, OP_CLR: begin
                e = (op == OP_SET);
                exp_q.push_back(e ? 2'b10 : 2'b01);
                resolve(e);
            end
            default: begin
                if (!m_known) begin
                    m_err[1] = 1'b1;
                    m_cnt    = m_cnt + 1'b1;
                end else begin
                    e = ~m_q;
                    exp_q.push_back({e, ~e});
                    resolve(e);
                end
            end
        endcase
    endtask

    task automatic push(input logic [1:0] op);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model(op);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(busy), 32'd0);
        check({tag, "_cnt"}, 32'(done_cnt), 32'(m_cnt));
        check({tag, "_err"}, 32'(err), 32'(m_err));
        check({tag, "_q"}, 32'(q_fb), 32'(m_q));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_known = 1'b0;
        m_err   = 2'b00;
        m_cnt   = '0;
        exp_q.delete();
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        m_err   = 2'b00;
        check("err_clr", 32'(err), 32'd0);
    endtask

    initial begin
        logic saved_q;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_s", 32'(s_out), 32'd0);
        check("rst_r", 32'(r_out), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt", 32'(done_cnt), 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));
        rst_n = 1'b1;

        // SET latency: pulse one edge after accept, count after the readback edge
        push(OP_SET);
        check("set_lat0_s", 32'(s_out), 32'd0);
        @(posedge clk); #1;
        check("set_lat1_s", 32'(s_out), 32'd1);
        check("set_lat1_r", 32'(r_out), 32'd0);
        check("set_lat1_state", 32'(state), 32'(DRIVE));
        @(posedge clk); #1;
        check("set_lat2_s", 32'(s_out), 32'd0);
        check("set_lat2_cnt", 32'(done_cnt), 32'd0);
        @(posedge clk); #1;
        check("set_lat3_cnt", 32'(done_cnt), 32'd1);
        check("set_lat3_q", 32'(q_fb), 32'd1);
        check("set_lat3_err", 32'(err), 32'd0);
        drain("t_set");

        // TOGGLE before Q is known is dropped with err[1]
        do_reset();
        push(OP_TOGGLE);
        drain("t_tog0");
        check("tog0_err", 32'(err), 32'd2);
        push(OP_CLR);
        push(OP_TOGGLE);
        drain("t_tog1");
        check("tog1_q", 32'(q_fb), 32'd1);
        check("tog1_cnt", 32'(done_cnt), 32'd3);
        clear_err();

        // back-pressure: five commands queued behind an executing SET
        push(OP_SET);
        for (int i = 0; i < 5; i++) begin
            push(2'($urandom_range(1, 3)));
            if (i == 3) check("bp_ready_4", 32'(in_ready), 32'd1);
            if (i == 4) check("bp_ready_full", 32'(in_ready), 32'd0);
        end
        drain("t_bp");

        // readback mismatch with Q stuck at 0
        @(negedge clk);
        stuck = 1'b1;
        m_q   = 1'b0;
        @(negedge clk);
        push(OP_SET);
        repeat (3) @(posedge clk);
        #1;
        check("mm_err0", 32'(err[0]), 32'd1);
        drain("t_mm");
        clear_err();
        stuck = 1'b0;

        // reset during DRIVE discards the pulse and the queued command
        saved_q = m_q;
        push(OP_SET);
        push(OP_CLR);
        check("rd_s_before", 32'(s_out), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rd_s", 32'(s_out), 32'd0);
        check("rd_r", 32'(r_out), 32'd0);
        check("rd_busy", 32'(busy), 32'd0);
        check("rd_cnt", 32'(done_cnt), 32'd0);
        check("rd_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n   = 1'b1;
        m_q     = saved_q;
        m_known = 1'b0;
        m_err   = 2'b00;
        m_cnt   = '0;
        exp_q.delete();
        drain("t_rd");

        // randomized mix with random gaps
        for (int i = 0; i < 40; i++) begin
            push(2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain("t_rand");

        // counter wrap
        do_reset();
        for (int i = 0; i < 255; i++) push(OP_NOP);
        drain("t_wrap255");
        push(OP_NOP);
        drain("t_wrap256");
        check("wrap_zero", 32'(done_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
